// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - multi-digit BCD down-counter with load/start/stop control and done flag
// Decrements on qualified ticks with borrow rippling across digits; halts and flags done at zero.
module bcd_countdown_timer #(
    parameter int DIGITS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                tick,
    input  logic                load,
    input  logic [4*DIGITS-1:0] preset,
    input  logic                start,
    input  logic                stop,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                done,
    output logic                done_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    logic [4*DIGITS-1:0] preset_clamped;
    logic [4*DIGITS-1:0] count_dec;
    logic                count_zero;
    logic                dec_zero;

    // Any non-BCD preset digit saturates to 9 so count always stays legal BCD.
    always_comb begin
        preset_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (preset[4*i +: 4] > 4'd9) begin
                preset_clamped[4*i +: 4] = 4'd9;
            end else begin
                preset_clamped[4*i +: 4] = preset[4*i +: 4];
            end
        end
    end

    // Digit 0 always decrements; a borrow propagates upward past every digit that was 0.
    always_comb begin
        logic borrow;
        logic [3:0] d;
        count_dec = '0;
        borrow    = 1'b1;
        d         = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                    borrow              = 1'b1;
                end else begin
                    count_dec[4*i +: 4] = d - 4'd1;
                    borrow              = 1'b0;
                end
            end else begin
                count_dec[4*i +: 4] = d;
            end
        end
    end

    assign count_zero = (count == '0);
    assign dec_zero   = (count_dec == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            count      <= '0;
            running    <= 1'b0;
            done       <= 1'b0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= 1'b0;
            if (load) begin
                count   <= preset_clamped;
                state   <= IDLE;
                running <= 1'b0;
                done    <= 1'b0;
            end else if (stop) begin
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end
            end else if (start) begin
                if ((state == IDLE || state == PAUSE) && !count_zero) begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end else if (tick && state == RUN) begin
                count <= count_dec;
                if (dec_zero) begin
                    state      <= DONE;
                    running    <= 1'b0;
                    done       <= 1'b1;
                    done_pulse <= 1'b1;
                end
            end
        end
    end

endmodule
